logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Two-port arbiter and sequencer for the shared 32-bit bitwise logic unit (AND/OR/XOR/NOR) in the MIPS datapath. It lets two requesters, e.g. the integer pipeline and the checksum/debug path, share one logic unit without duplicating it. Each operation is accepted via a valid/ready handshake, executed in one registered cycle and returned on a held response until the requester acknowledges it. Grants alternate round-robin when both requesters are active.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 presents an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a, req0_b  in  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  out  1  result pending for requester 0
- rsp0_ready  in  1  requester 0 takes the result
- rsp1_valid, rsp1_ready: same as the requester 0 pair, for requester 1
- rsp_data  out  WIDTH  result; meaningful only while either rsp*_valid is high
- busy  out  1  state is not IDLE
- done_count  out  CNT_W  completed response handshakes, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational over req*_valid.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester selected by priority pointer prio_q wins.
  - The winner's req*_ready is high in the same cycle. On that edge, op/a/b are latched, owner_q is set to the winner, prio_q is set to the other requester, and the FSM goes to EXEC.
- EXEC:
  - The shared logic unit evaluates the latched op/a/b.
  - The result is registered into res_q.
  - The FSM goes to RESP unconditionally.
- RESP:
  - rsp{owner_q}_valid is high and rsp_data = res_q.
  - State is held indefinitely until rsp{owner_q}_ready.
  - On the handshake edge: FSM goes to IDLE and done_count increments.
  - The non-owner's rsp_ready is ignored.
- Both req*_ready are low in EXEC and RESP.
- Requesters hold valid/op/a/b stable until ready. A valid deasserted before grant is legal and simply drops out of arbitration.
- NOR result is the bitwise complement of OR, full WIDTH.
- Only one operation is in flight; there is no queuing.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=IDLE, prio_q=0 (requester 0 favoured), owner_q=0.
  - res_q=0, done_count=0.
  - All req*_ready low unless granted in IDLE, all rsp*_valid=0, rsp_data=0, busy=0.
- Latency, taking the accept edge as T:
  - Result latched at edge T+1.
  - rsp*_valid is high from just after T+1.
  - With rsp_ready held high, the response completes at edge T+2 and the FSM is in IDLE for the cycle after.
- Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP). A requester waiting during RESP is granted in the next IDLE cycle.
- Simultaneous requests: grants strictly alternate 0,1,0,1... starting with 0 after reset.
- Single active requester: it is granted every time, regardless of prio_q. prio_q still updates to the other requester after each grant.
- A new request asserted in the same cycle as the response handshake is not accepted until the following IDLE cycle.
- Reset mid-operation (EXEC or RESP): the operation is discarded with no response and done_count clears. Requesters must reissue.
- done_count wraps to 0 after 2^CNT_W−1, with no flag.

## Structure
- Shared package logic_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - the FSM state encoding (IDLE/EXEC/RESP);
  - WIDTH default 32.
- Sub-module logic_unit: combinational, WIDTH-bit, takes op, a, b and gives y. It is built on the existing 32-bit AND/OR/XOR gate-array modules plus inversion for NOR.
- logic_unit_arbiter contains the FSM, arbitration, operand/result registers and done_count. There is a single logic_unit instance.

## Test plan
- Single XOR, no backpressure:
  - Stimulus: after reset, req0 op=10, a=0xFFFF0000, b=0x0F0F0F0F, rsp0_ready=1.
  - Required: req0_ready high in the first cycle; rsp0_valid one cycle, starting 2 cycles after accept; rsp_data=0xF0F00F0F; done_count=1.
- Contention:
  - Stimulus: req0 and req1 both valid continuously with distinct ops, 4 operations total.
  - Required: grant order 0,1,0,1; each rsp_data matches its own op; the other requester's rsp_valid stays low.
- Backpressure:
  - Stimulus: req1 NOR, a=0, b=0x00000001, with rsp1_ready held low 5 cycles.
  - Required: rsp1_valid and rsp_data=0xFFFFFFFE stable all 5 cycles; req0 not granted; one count increments on release.
- Reset mid-operation:
  - Stimulus: assert rst_n low during EXEC, then during RESP.
  - Required: immediately all outputs take their reset values; no response is emitted afterwards; the next request is granted to requester 0 first.
- Counter wrap:
  - Stimulus: CNT_W=4, run 17 back-to-back AND ops.
  - Required: done_count reads 1 after the 17th response.
- All opcodes sweep:
  - Stimulus: a=0xA5A5A5A5, b=0x3C3C3C3C.
  - Required: AND=0x24242424, OR=0xBDBDBDBD, XOR=0x99999999, NOR=0x42424242.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the bitwise logic unit and its two-port arbiter.
// Contents: default datapath width, opcode encodings, sequencer state encoding.
package logic_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OP_W  = 2;

    // Opcode encodings presented on req*_op
    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_NOR = 2'b11;

    // Sequencer states: accept, evaluate, hold result
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational WIDTH-bit bitwise logic unit.
// Ports: op (opcode), a/b (operands) -> y (result). NOR is the full-width
// complement of the OR term.
module logic_unit #(
    parameter int unsigned WIDTH = logic_pkg::WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    import logic_pkg::*;

    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] xor_y;

    // Gate arrays shared by all opcodes
    assign and_y = a & b;
    assign or_y  = a | b;
    assign xor_y = a ^ b;

    // Opcode select
    always_comb begin
        y = and_y;
        case (op)
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            OP_NOR:  y = ~or_y;
            default: y = and_y;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-port arbiter/sequencer sharing one logic_unit between two requesters.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req{0,1}_valid/_ready/_op/_a/_b    operation request handshake
//   rsp{0,1}_valid/_ready              held response handshake
//   rsp_data                           result while a rsp*_valid is high
//   busy                               sequencer not idle
//   done_count                         completed responses, wraps
// req*_ready is decoded combinationally in IDLE so the grant lands in the
// same cycle as the request; rsp*_valid/rsp_data/busy decode registered state.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = logic_pkg::WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    import logic_pkg::*;

    state_e           state_q;
    state_e           state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] lu_y;
    logic             owner_q;
    logic             prio_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             rsp_hs;

    // Single shared logic unit, fed only from latched operands
    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (lu_y)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and handshake decode
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_hs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A lone requester wins regardless of the pointer
                if (req0_valid && (!req1_valid || !prio_q)) begin
                    req0_ready = 1'b1;
                    state_d    = ST_EXEC;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                // Only the owner's ready can complete the response
                rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // Operand capture, ownership/priority, result and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            count_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req1_ready ? req1_op : req0_op;
                a_q     <= req1_ready ? req1_a  : req0_a;
                b_q     <= req1_ready ? req1_b  : req0_b;
                owner_q <= req1_ready;
                prio_q  <= !req1_ready;
            end
            if (state_q == ST_EXEC) begin
                res_q <= lu_y;
            end
            if (rsp_hs) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Result is only driven while a response is held
    assign rsp_data   = (state_q == ST_RESP) ? res_q : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done_count = count_q;

endmodule
